instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Producer end of the instruction path: generates the PC, fetches RV32I words from instruction memory over a req/ready handshake, and drives the IF/ID register that feeds the decoder.
- Handles ID-stage stall, redirects from JAL/JALR in ID and taken branches in EX, and variable-latency memory. Sustains one instruction per cycle when memory returns ready in the same cycle as the request.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) placed in IF/ID on flush or empty fetch.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- Stall  in  1  hazard stall from ID; holds the PC and IF/ID.
- Jump  in  1  JAL/JALR redirect from ID.
- JumpAddr  in  32  redirect target from ID.
- Branch  in  1  taken-branch redirect from EX.
- BranchAddr  in  32  redirect target from EX.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; bits [1:0] always 00.
- imem_ready  in  1  memory has returned data this cycle.
- imem_rdata  in  32  instruction word; valid only when imem_req && imem_ready.
- Instruction_id  out  32  IF/ID instruction.
- PC_id  out  32  IF/ID PC.
- Valid_id  out  1  IF/ID holds a real instruction.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: pc=RESET_PC, state=FETCH, Instruction_id=NOP_INSTR, PC_id=0, Valid_id=0, pending target=0, buffer=NOP_INSTR. imem_req=0 in any cycle where reset=1.
- Reset asserted mid-transaction: the outstanding request is abandoned, with no KILL drain. Memory must tolerate request withdrawal on reset.
- Handshake:
  - imem_req is high in FETCH and KILL.
  - imem_addr must stay stable from req rise until the cycle in which ready=1.
  - Only one transaction is outstanding at a time.
  - Zero-wait memory returns ready=1 in the same cycle as the request.
- Redirect selection: redir = Branch|Jump. Target = Branch ? BranchAddr : JumpAddr (older instruction wins). Target[1:0] is forced to 00.
- Priority: reset > redir > Stall > normal. A redirect overrides Stall.
- Any redir: next IF/ID = {NOP_INSTR, PC_id unchanged, Valid_id=0}.
- States:
  - FETCH, redir:
    - ready=1: pc<=target; data dropped; stay FETCH.
    - ready=0: pend<=target; go KILL.
  - FETCH, Stall, ready=1: IF/ID holds; buf<=imem_rdata; go HOLD.
  - FETCH, Stall, ready=0: IF/ID holds; request continues.
  - FETCH, normal, ready=1: IF/ID <= {imem_rdata, pc, 1}; pc<=pc+4.
  - FETCH, normal, ready=0: IF/ID <= bubble (NOP_INSTR, valid 0); pc holds.
  - HOLD (imem_req=0):
    - redir: buffer discarded; pc<=target; go FETCH.
    - Stall: IF/ID and buf hold.
    - otherwise: IF/ID <= {buf, pc, 1}; pc<=pc+4; go FETCH.
  - KILL (imem_addr = old pc):
    - redir: pend<=target (latest wins).
    - ready=1: data dropped; pc<=pend (or the new target if redir this cycle); go FETCH.
    - IF/ID stays bubble unless Stall is high without redir, in which case it holds.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Latency: redirect in cycle N with zero-wait memory -> target instruction appears in IF/ID after edge N+1. Each ready=0 cycle adds one bubble.

Decomposition:
- Shared package: NOP_INSTR constant, fetch state encoding (FETCH/HOLD/KILL), RESET_PC default.
- One natural sub-module: if_id_reg, the IF/ID register with load/hold/flush controls and synchronous reset to bubble. PC generation, the state machine and the skid buffer stay in instr_fetch.

Test Plan:
- Zero-wait memory, ready tied 1, no stall, 4 cycles after reset -> PC_id 0,4,8,12, Valid_id=1 each cycle, Instruction_id matches memory at those addresses.
- Stall=1 for 3 cycles while the word at 0x10 returns -> IF/ID holds the 0x0C entry and imem_req=0 in HOLD. After Stall drops, IF/ID = word@0x10 with no duplicate and no loss.
- Memory ready 3 cycles late, Branch=1 with BranchAddr=0x40 in the first wait cycle -> imem_addr stays at old pc until ready, returned word is dropped, next imem_addr=0x40, Valid_id=0 throughout.
- Branch=1 (0x80) and Jump=1 (0x200) in the same cycle -> next fetch at 0x80; IF/ID flushed to 0x00000013 with Valid_id=0.
- Jump=1 with JumpAddr=0x103 while Stall=1 -> redirect wins; fetch address 0x100.
- reset pulsed for 1 cycle while in KILL -> imem_req=0 that cycle; outputs reset; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared constants and the fetch state encoding for the instruction fetch stage.
package instr_fetch_pkg;

  // Bubble word: addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  // FETCH: request outstanding for pc.
  // HOLD : fetched word parked in the skid buffer while ID stalls; no request.
  // KILL : request for a stale pc still in flight; its data will be dropped.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_KILL  = 2'd2
  } fetch_state_e;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: load a new entry, hold it, or flush it to a bubble.
module if_id_reg
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        valid_q;

  // Load has priority over flush; a flush keeps the PC so it still tracks the last slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end else if (flush_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC generation, imem req/ready handshake, skid buffer for
// ID stalls, redirect handling, and the IF/ID register feeding decode.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Jump,
  input  logic [31:0] JumpAddr,
  input  logic        Branch,
  input  logic [31:0] BranchAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_id,
  output logic [31:0] PC_id,
  output logic        Valid_id
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;
  logic [31:0]  buf_q, buf_d;

  logic         redir;
  logic [31:0]  target;
  logic         ifid_load;
  logic         ifid_flush;
  logic [31:0]  ifid_instr;

  // Branch comes from EX and is older than the jump in ID, so it wins.
  assign redir  = Branch | Jump;
  assign target = align_word(Branch ? BranchAddr : JumpAddr);

  // In KILL pc_q still holds the stale address, keeping imem_addr stable until ready.
  assign imem_req  = !reset && ((state_q == ST_FETCH) || (state_q == ST_KILL));
  assign imem_addr = pc_q;

  // Next-state, PC selection and IF/ID control; redirect overrides Stall.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    buf_d      = buf_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_instr = imem_rdata;
    case (state_q)
      ST_FETCH: begin
        if (redir) begin
          ifid_flush = 1'b1;
          if (imem_ready) begin
            pc_d = target;
          end else begin
            pend_d  = target;
            state_d = ST_KILL;
          end
        end else if (Stall) begin
          if (imem_ready) begin
            buf_d   = imem_rdata;
            state_d = ST_HOLD;
          end
        end else if (imem_ready) begin
          ifid_load = 1'b1;
          pc_d      = pc_q + 32'd4;
        end else begin
          ifid_flush = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redir) begin
          ifid_flush = 1'b1;
          pc_d       = target;
          state_d    = ST_FETCH;
        end else if (!Stall) begin
          ifid_load  = 1'b1;
          ifid_instr = buf_q;
          pc_d       = pc_q + 32'd4;
          state_d    = ST_FETCH;
        end
      end
      ST_KILL: begin
        // A stall without redirect must not disturb the instruction sitting in ID.
        ifid_flush = redir || !Stall;
        if (redir) begin
          pend_d = target;
        end
        if (imem_ready) begin
          pc_d    = redir ? target : pend_q;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State, PC, pending redirect target and skid buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= align_word(RESET_PC);
      pend_q  <= 32'h0000_0000;
      buf_q   <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .instr_i (ifid_instr),
    .pc_i    (pc_q),
    .instr_o (Instruction_id),
    .pc_o    (PC_id),
    .valid_o (Valid_id)
  );

endmodule
